// File: rtl/frame_replay_tx_if.sv
// Pixel-stream and pixel-memory read bus between the frame replay transmitter
// and its memory / downstream receiver.
interface frame_replay_tx_if;
   logic [16:0] addr_out;
   logic [15:0] pixel_mem_in;
   logic        valid_pixel_out;
   logic [15:0] pixel_out;
   logic        frame_done_out;
   logic [10:0] hcount_out;
   logic [9:0]  vcount_out;

   modport master (
      output addr_out,
      input  pixel_mem_in,
      output valid_pixel_out,
      output pixel_out,
      output frame_done_out,
      output hcount_out,
      output vcount_out
   );

   modport slave (
      input  addr_out,
      output pixel_mem_in,
      input  valid_pixel_out,
      input  pixel_out,
      input  frame_done_out,
      input  hcount_out,
      input  vcount_out
   );
endinterface

// File: rtl/frame_replay_tx.sv
// Replays a stored frame from pixel memory as a camera-style pixel stream:
// one valid pulse per pixel, line/frame blanking, and a one-cycle frame-done strobe.
module frame_replay_tx #(
   parameter int H_ACTIVE    = 320,
   parameter int V_ACTIVE    = 240,
   parameter int MEM_LATENCY = 2,
   parameter int VALID_HIGH  = 2,
   parameter int VALID_LOW   = 2,
   parameter int LINE_BLANK  = 16,
   parameter int FRAME_BLANK = 64
) (
   input  logic               system_clk_in,
   input  logic               rst_in,
   input  logic               start_in,
   input  logic               continuous_in,
   output logic               busy_out,
   frame_replay_tx_if.master  px
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_HIGH   = 3'd2;
   localparam logic [2:0] S_LOW    = 3'd3;
   localparam logic [2:0] S_LBLANK = 3'd4;
   localparam logic [2:0] S_FDONE  = 3'd5;
   localparam logic [2:0] S_FBLANK = 3'd6;

   // Shared timer is loaded with (duration-1) on state entry and exits at zero.
   localparam logic [15:0] LD_FETCH  = 16'(MEM_LATENCY - 1);
   localparam logic [15:0] LD_HIGH   = 16'(VALID_HIGH - 1);
   localparam logic [15:0] LD_LOW    = 16'(VALID_LOW - 1);
   localparam logic [15:0] LD_LBLANK = 16'(LINE_BLANK - 1);
   localparam logic [15:0] LD_FBLANK = 16'(FRAME_BLANK - 1);
   localparam logic [10:0] X_LAST    = 11'(H_ACTIVE - 1);
   localparam logic [9:0]  Y_LAST    = 10'(V_ACTIVE - 1);

   logic [2:0]  state;
   logic [15:0] cnt;
   logic [10:0] x;
   logic [9:0]  y;
   logic        cnt_zero;

   assign cnt_zero = (cnt == 16'd0);
   assign busy_out = (state != S_IDLE);

   always_ff @(posedge system_clk_in) begin
      if (rst_in) begin
         state              <= S_IDLE;
         cnt                <= 16'd0;
         x                  <= 11'd0;
         y                  <= 10'd0;
         px.addr_out        <= 17'd0;
         px.valid_pixel_out <= 1'b0;
         px.pixel_out       <= 16'd0;
         px.frame_done_out  <= 1'b0;
         px.hcount_out      <= 11'd0;
         px.vcount_out      <= 10'd0;
      end else begin
         px.frame_done_out <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_in) begin
                  state       <= S_FETCH;
                  cnt         <= LD_FETCH;
                  x           <= 11'd0;
                  y           <= 10'd0;
                  px.addr_out <= 17'd0;
               end
            end
            S_FETCH: begin
               if (cnt_zero) begin
                  state              <= S_HIGH;
                  cnt                <= LD_HIGH;
                  px.pixel_out       <= px.pixel_mem_in;
                  px.hcount_out      <= x;
                  px.vcount_out      <= y;
                  px.valid_pixel_out <= 1'b1;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            S_HIGH: begin
               if (cnt_zero) begin
                  state              <= S_LOW;
                  cnt                <= LD_LOW;
                  px.valid_pixel_out <= 1'b0;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            S_LOW: begin
               if (!cnt_zero) begin
                  cnt <= cnt - 16'd1;
               end else if (x != X_LAST) begin
                  state       <= S_FETCH;
                  cnt         <= LD_FETCH;
                  x           <= x + 11'd1;
                  px.addr_out <= px.addr_out + 17'd1;
               end else if (y != Y_LAST) begin
                  state       <= S_LBLANK;
                  cnt         <= LD_LBLANK;
                  x           <= 11'd0;
                  y           <= y + 10'd1;
                  px.addr_out <= px.addr_out + 17'd1;
               end else begin
                  state             <= S_FDONE;
                  px.frame_done_out <= 1'b1;
               end
            end
            S_LBLANK: begin
               if (cnt_zero) begin
                  state <= S_FETCH;
                  cnt   <= LD_FETCH;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            S_FDONE: begin
               state <= S_FBLANK;
               cnt   <= LD_FBLANK;
            end
            S_FBLANK: begin
               if (!cnt_zero) begin
                  cnt <= cnt - 16'd1;
               end else if (continuous_in) begin
                  state       <= S_FETCH;
                  cnt         <= LD_FETCH;
                  x           <= 11'd0;
                  y           <= 10'd0;
                  px.addr_out <= 17'd0;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_replay_tx.sv
// Directed bench for frame_replay_tx with a small frame, a registered memory
// model, a pixel scoreboard and a loopback pixel-counting receiver model.
module tb_frame_replay_tx;

   localparam int H  = 4;
   localparam int V  = 3;
   localparam int ML = 2;
   localparam int VH = 2;
   localparam int VL = 2;
   localparam int LB = 3;
   localparam int FB = 5;
   localparam int P  = ML + VH + VL;
   localparam int FRAME_CYC = H * V * P + (V - 1) * LB + 1 + FB;

   typedef struct {
      logic [15:0] pix;
      logic [10:0] h;
      logic [9:0]  v;
      int unsigned cyc;
   } exp_t;

   logic system_clk_in = 1'b0;
   logic rst_in        = 1'b1;
   logic start_in      = 1'b0;
   logic continuous_in = 1'b0;
   logic busy_out;

   frame_replay_tx_if pif ();

   frame_replay_tx #(
      .H_ACTIVE    (H),
      .V_ACTIVE    (V),
      .MEM_LATENCY (ML),
      .VALID_HIGH  (VH),
      .VALID_LOW   (VL),
      .LINE_BLANK  (LB),
      .FRAME_BLANK (FB)
   ) dut (
      .system_clk_in (system_clk_in),
      .rst_in        (rst_in),
      .start_in      (start_in),
      .continuous_in (continuous_in),
      .busy_out      (busy_out),
      .px            (pif)
   );

   always #5 system_clk_in = ~system_clk_in;

   // Registered read: data for an address change at edge k is sampled at edge k+2.
   always @(posedge system_clk_in) pif.pixel_mem_in <= 16'hA000 | pif.addr_out[15:0];

   int unsigned cyc = 0;
   always @(posedge system_clk_in) cyc <= cyc + 1;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];
   int unsigned done_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_frame(input int unsigned k);
      exp_t e;
      int unsigned last_rise;
      last_rise = 0;
      for (int i = 0; i < H * V; i++) begin
         e.pix = 16'hA000 | 16'(i);
         e.h   = 11'(i % H);
         e.v   = 10'(i / H);
         e.cyc = k + ML + i * P + (i / H) * LB;
         last_rise = e.cyc;
         exp_q.push_back(e);
      end
      done_q.push_back(last_rise + VH + VL);
   endtask

   task automatic wait_until(input int unsigned c);
      while (cyc < c) @(negedge system_clk_in);
   endtask

   task automatic wait_busy_low(input int unsigned limit);
      while (busy_out && cyc < limit) @(negedge system_clk_in);
   endtask

   task automatic start_pulse(output int unsigned k);
      start_in = 1'b1;
      k = cyc + 1;
      @(negedge system_clk_in);
      start_in = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_addr"},  32'(pif.addr_out), 32'd0);
      chk({tag, "_valid"}, 32'(pif.valid_pixel_out), 32'd0);
      chk({tag, "_pixel"}, 32'(pif.pixel_out), 32'd0);
      chk({tag, "_done"},  32'(pif.frame_done_out), 32'd0);
      chk({tag, "_h"},     32'(pif.hcount_out), 32'd0);
      chk({tag, "_v"},     32'(pif.vcount_out), 32'd0);
      chk({tag, "_busy"},  32'(busy_out), 32'd0);
   endtask

   // Scoreboard pops on each valid rise; receiver model counts rises and clears on frame done.
   logic [10:0] rx_h = '0;
   logic [9:0]  rx_v = '0;
   logic        prev_vld  = 1'b0;
   logic        prev_done = 1'b0;
   initial begin
      exp_t e;
      int unsigned dc;
      forever begin
         @(negedge system_clk_in);
         if (rst_in) begin
            rx_h = '0;
            rx_v = '0;
         end else begin
            if (pif.valid_pixel_out && !prev_vld) begin
               chk("pixel_pending", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("pixel_value", 32'(pif.pixel_out), 32'(e.pix));
                  chk("pixel_h", 32'(pif.hcount_out), 32'(e.h));
                  chk("pixel_v", 32'(pif.vcount_out), 32'(e.v));
                  chk("rise_cycle", cyc, e.cyc);
               end
               chk("rx_h", 32'(pif.hcount_out), 32'(rx_h));
               chk("rx_v", 32'(pif.vcount_out), 32'(rx_v));
               if (rx_h == 11'(H - 1)) begin
                  rx_h = '0;
                  rx_v = rx_v + 10'd1;
               end else begin
                  rx_h = rx_h + 11'd1;
               end
            end
            if (pif.frame_done_out) begin
               chk("done_without_valid", 32'(pif.valid_pixel_out), 32'd0);
               chk("done_single_cycle", 32'(prev_done), 32'd0);
               chk("done_pending", 32'(done_q.size() != 0), 32'd1);
               if (done_q.size() != 0) begin
                  dc = done_q.pop_front();
                  chk("done_cycle", cyc, dc);
               end
               rx_h = '0;
               rx_v = '0;
            end
         end
         prev_vld  = pif.valid_pixel_out;
         prev_done = pif.frame_done_out;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned k;
      repeat (3) @(negedge system_clk_in);
      chk_all_zero("reset");
      rst_in = 1'b0;
      @(negedge system_clk_in);

      // Abort mid-HIGH of pixel 5 (line 1, x=1).
      start_pulse(k);
      for (int i = 0; i < H * V; i++) if (i <= 5) begin
         exp_t e;
         e.pix = 16'hA000 | 16'(i);
         e.h   = 11'(i % H);
         e.v   = 10'(i / H);
         e.cyc = k + ML + i * P + (i / H) * LB;
         exp_q.push_back(e);
      end
      wait_until(k + ML + 5 * P + LB);
      chk("abort_in_high", 32'(pif.valid_pixel_out), 32'd1);
      rst_in = 1'b1;
      @(negedge system_clk_in);
      chk_all_zero("abort");
      chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);
      rst_in = 1'b0;
      repeat (2) @(negedge system_clk_in);

      // Single frame, continuous off.
      start_pulse(k);
      push_frame(k);
      chk("single_addr0", 32'(pif.addr_out), 32'd0);
      chk("single_busy", 32'(busy_out), 32'd1);
      wait_until(k + P);
      chk("single_addr1", 32'(pif.addr_out), 32'd1);
      wait_busy_low(k + FRAME_CYC + 20);
      chk("single_busy_fall", cyc, k + FRAME_CYC);
      chk("single_pixels_left", 32'(exp_q.size()), 32'd0);
      chk("single_done_left", 32'(done_q.size()), 32'd0);

      // start held high for the whole frame: one frame, restart only from IDLE.
      start_in = 1'b1;
      k = cyc + 1;
      push_frame(k);
      @(negedge system_clk_in);
      chk("held_addr0", 32'(pif.addr_out), 32'd0);
      wait_until(k + FRAME_CYC - 1);
      chk("held_busy_before_end", 32'(busy_out), 32'd1);
      wait_until(k + FRAME_CYC);
      chk("held_busy_low", 32'(busy_out), 32'd0);
      chk("held_pixels_left", 32'(exp_q.size()), 32'd0);
      wait_until(k + FRAME_CYC + 1);
      chk("held_restart_busy", 32'(busy_out), 32'd1);
      start_in = 1'b0;
      rst_in = 1'b1;
      @(negedge system_clk_in);
      chk("held_reset_busy", 32'(busy_out), 32'd0);
      rst_in = 1'b0;
      repeat (2) @(negedge system_clk_in);

      // Continuous mode: second frame follows the frame blank, then stop.
      continuous_in = 1'b1;
      start_pulse(k);
      push_frame(k);
      push_frame(k + FRAME_CYC);
      wait_until(k + FRAME_CYC - 1);
      chk("cont_addr_end_frame1", 32'(pif.addr_out), 32'(H * V - 1));
      wait_until(k + FRAME_CYC);
      chk("cont_addr_restart", 32'(pif.addr_out), 32'd0);
      chk("cont_busy_between", 32'(busy_out), 32'd1);
      wait_until(k + FRAME_CYC + 6);
      continuous_in = 1'b0;
      wait_busy_low(k + 2 * FRAME_CYC + 20);
      chk("cont_busy_fall", cyc, k + 2 * FRAME_CYC);
      chk("cont_pixels_left", 32'(exp_q.size()), 32'd0);
      chk("cont_done_left", 32'(done_q.size()), 32'd0);
      repeat (3) @(negedge system_clk_in);
      chk("cont_stays_idle", 32'(busy_out), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
